// File: rtl/iram_pkg.sv
// Shared definitions for the instruction-memory loader.
// No ports: provides the FSM state encoding, memory geometry and sum width.
package iram_pkg;

  localparam int unsigned DEPTH  = 128;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 8;  // holds 0..DEPTH and the readback phase counter
  localparam int unsigned SUM_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_READBACK = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/iram_loader_if.sv
// Bundle of the loader's stream, memory and status signals.
// slave  : loader side (consumes stream and read data, drives memory port and status)
// master : environment side (upstream source, instruction memory, CPU).
interface iram_loader_if;
  import iram_pkg::*;

  logic              load_start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic              cpu_hold;
  logic              overflow_err;
  logic              checksum_err;

  modport slave (
    input  load_start, in_valid, in_data, in_last, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count,
           busy, done, cpu_hold, overflow_err, checksum_err
  );

  modport master (
    output load_start, in_valid, in_data, in_last, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata, word_count,
           busy, done, cpu_hold, overflow_err, checksum_err
  );

endinterface

// File: rtl/iram_checksum.sv
// Mod-256 additive accumulator with synchronous clear and add enable.
// Ports: clock, reset (sync, active-high), clr_i, add_en_i, data_i,
//        sum_o (registered sum), sum_nxt_c (sum_o + data_i, combinational).
module iram_checksum
  import iram_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             add_en_i,
  input  logic [SUM_W-1:0] data_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [SUM_W-1:0] sum_nxt_c
);

  logic [SUM_W-1:0] sum_q;

  assign sum_nxt_c = sum_q + data_i;
  assign sum_o     = sum_q;

  always_ff @(posedge clock) begin
    if (reset || clr_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_nxt_c;
    end
  end

endmodule

// File: rtl/iram_loader.sv
// Loads an instruction image from a valid/ready stream into instruction memory,
// reads it back, verifies an additive checksum and releases the CPU on success.
// Ports: clock, reset (sync, active-high), bus (iram_loader_if.slave):
//   stream in (load_start, in_valid/in_data/in_last, in_ready),
//   memory port (mem_we/mem_addr/mem_wdata registered, mem_rdata 1-cycle latency),
//   status (word_count, busy, done, cpu_hold, overflow_err, checksum_err).
module iram_loader
  import iram_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  iram_loader_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [CNT_W-1:0]  rb_cnt_q, rb_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              ovf_q, ovf_d;
  logic              csum_q, csum_d;

  logic              start_c, accept_c, at_top_c, rb_data_c, rb_last_c;
  logic              wsum_add, rsum_add;
  logic [SUM_W-1:0]  wsum, rsum, wsum_nxt, rsum_nxt;

  assign start_c  = bus.load_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept_c = (state_q == ST_LOAD) && in_ready_q && bus.in_valid;
  assign at_top_c = (word_count_q == CNT_W'(DEPTH - 1));

  // READBACK phase k: address k is issued for k < N; data of address k-2 returns for 2 <= k <= N+1.
  // Phase 0 coincides with the final write on the port, so no read precedes its write.
  assign rb_data_c = (state_q == ST_READBACK) && (rb_cnt_q >= CNT_W'(2)) &&
                     (rb_cnt_q <= word_count_q + CNT_W'(1));
  assign rb_last_c = (state_q == ST_READBACK) && (rb_cnt_q == word_count_q + CNT_W'(1));

  iram_checksum u_wsum (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (start_c),
    .add_en_i  (wsum_add),
    .data_i    ({1'b0, bus.in_data}),
    .sum_o     (wsum),
    .sum_nxt_c (wsum_nxt)
  );

  iram_checksum u_rsum (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (start_c),
    .add_en_i  (rsum_add),
    .data_i    ({1'b0, bus.mem_rdata}),
    .sum_o     (rsum),
    .sum_nxt_c (rsum_nxt)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_c) state_d = ST_LOAD;
      ST_LOAD:     if (accept_c && (bus.in_last || at_top_c)) state_d = ST_READBACK;
      ST_READBACK: if (rb_last_c) state_d = ST_DONE;
      ST_DONE:     if (start_c) state_d = ST_LOAD;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; status outputs decode the next state so they are registered
  always_comb begin
    word_count_d = word_count_q;
    rb_cnt_d     = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = mem_wdata_q;
    ovf_d        = ovf_q;
    csum_d       = csum_q;
    wsum_add     = 1'b0;
    rsum_add     = 1'b0;

    if (start_c) begin
      word_count_d = '0;
      ovf_d        = 1'b0;
      csum_d       = 1'b0;
    end

    if (accept_c) begin
      mem_we_d     = 1'b1;
      mem_addr_d   = word_count_q[ADDR_W-1:0];
      mem_wdata_d  = bus.in_data;
      word_count_d = word_count_q + CNT_W'(1);
      wsum_add     = 1'b1;
      if (at_top_c && !bus.in_last) ovf_d = 1'b1;
    end

    if (state_q == ST_READBACK) begin
      rb_cnt_d = rb_cnt_q + CNT_W'(1);
      if (rb_cnt_q < word_count_q) mem_addr_d = rb_cnt_q[ADDR_W-1:0];
      rsum_add = rb_data_c;
      if (rb_last_c) csum_d = (rsum_nxt != wsum);
    end

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_READBACK);
    done_d     = (state_d == ST_DONE);
    cpu_hold_d = (state_d == ST_DONE) ? (ovf_d || csum_d) : 1'b1;
  end

  // Output and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      word_count_q <= '0;
      rb_cnt_q     <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
      ovf_q        <= 1'b0;
      csum_q       <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      rb_cnt_q     <= rb_cnt_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_hold_q   <= cpu_hold_d;
      ovf_q        <= ovf_d;
      csum_q       <= csum_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.word_count   = word_count_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cpu_hold     = cpu_hold_q;
  assign bus.overflow_err = ovf_q;
  assign bus.checksum_err = csum_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed self-checking bench for iram_loader with a synchronous memory model.
module tb_iram_loader;
  import iram_pkg::*;

  logic clk;
  logic reset;
  logic corrupt;
  int   n_chk;
  int   n_pass;
  int   wr_cnt;
  int   wr_base;
  int   n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  iram_loader_if bus ();

  iram_loader dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous read, optional bit-0 corruption of address 3 on read
  always_ff @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= mem[bus.mem_addr] ^ ((corrupt && bus.mem_addr == 7'd3) ? 7'd1 : 7'd0);
  end
  assign bus.mem_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (bus.mem_we) wr_cnt <= wr_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_start();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    step();
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 400) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; wr_cnt = 0; corrupt = 1'b0;
    reset = 1'b1;
    bus.load_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset values
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_word_count", 32'(bus.word_count), 32'd0);
    chk("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_errs", {30'd0, bus.overflow_err, bus.checksum_err}, 32'd0);

    // Five-word image
    do_start();
    chk("t1_start_ready_busy", {30'd0, bus.in_ready, bus.busy}, 32'd3);
    wr_base = wr_cnt;
    send(7'h01, 1'b0);
    chk("t1_w0", {16'd0, bus.mem_we, bus.mem_addr, 1'b0, bus.mem_wdata}, {16'd0, 1'b1, 7'd0, 1'b0, 7'h01});
    send(7'h02, 1'b0);
    send(7'h03, 1'b0);
    send(7'h7F, 1'b0);
    send(7'h10, 1'b1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("t1_w4", {16'd0, bus.mem_we, bus.mem_addr, 1'b0, bus.mem_wdata}, {16'd0, 1'b1, 7'd4, 1'b0, 7'h10});
    chk("t1_ready_drop", 32'(bus.in_ready), 32'd0);
    chk("t1_word_count", 32'(bus.word_count), 32'd5);
    step();
    chk("t1_rb_first", {16'd0, bus.mem_we, bus.mem_addr, 7'd0, bus.busy}, {16'd0, 1'b0, 7'd0, 7'd0, 1'b1});
    wait_done(n);
    chk("t1_rb_cycles", 32'(n), 32'd6);
    chk("t1_wsum", 32'(dut.wsum), 32'h95);
    chk("t1_hold_done", {30'd0, bus.cpu_hold, bus.done}, 32'd1);
    chk("t1_errs", {30'd0, bus.overflow_err, bus.checksum_err}, 32'd0);
    chk("t1_writes", 32'(wr_cnt - wr_base), 32'd5);
    chk("t1_mem", {4'd0, mem[0], mem[1], mem[2], mem[3]}, {4'd0, 7'h01, 7'h02, 7'h03, 7'h7F});
    chk("t1_mem4", 32'(mem[4]), 32'h10);
    step();
    chk("t1_done_stable", {22'd0, bus.word_count, bus.done, bus.mem_addr == 7'd0}, {22'd0, 8'd5, 1'b1, 1'b1});

    // Single-word image, started from DONE
    do_start();
    chk("t2_restart", {22'd0, bus.word_count, bus.cpu_hold, bus.done}, {22'd0, 8'd0, 1'b1, 1'b0});
    wr_base = wr_cnt;
    send(7'h2A, 1'b1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("t2_w0", {16'd0, bus.mem_we, bus.mem_addr, 1'b0, bus.mem_wdata}, {16'd0, 1'b1, 7'd0, 1'b0, 7'h2A});
    wait_done(n);
    chk("t2_rb_cycles", 32'(n), 32'd3);
    chk("t2_word_count", 32'(bus.word_count), 32'd1);
    chk("t2_wsum", 32'(dut.wsum), 32'h2A);
    chk("t2_hold_errs", {29'd0, bus.cpu_hold, bus.overflow_err, bus.checksum_err}, 32'd0);
    chk("t2_writes", 32'(wr_cnt - wr_base), 32'd1);

    // Overflow: 129 words offered without in_last
    do_start();
    wr_base = wr_cnt;
    for (int i = 0; i < 129; i++) begin
      send(7'(i), 1'b0);
      if (i == 127) chk("t3_ready_drop", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    wait_done(n);
    chk("t3_rb_cycles", 32'(n), 32'd129);
    chk("t3_writes", 32'(wr_cnt - wr_base), 32'd128);
    chk("t3_word_count", 32'(bus.word_count), 32'd128);
    chk("t3_errs", {30'd0, bus.overflow_err, bus.checksum_err}, 32'd2);
    chk("t3_hold_done", {30'd0, bus.cpu_hold, bus.done}, 32'd3);
    chk("t3_mem_ends", {18'd0, mem[0], mem[127]}, {18'd0, 7'd0, 7'd127});

    // Readback corruption at address 3
    corrupt = 1'b1;
    do_start();
    chk("t4_flags_cleared", {29'd0, bus.overflow_err, bus.checksum_err, bus.cpu_hold}, 32'd1);
    send(7'h11, 1'b0);
    send(7'h22, 1'b0);
    send(7'h33, 1'b0);
    send(7'h44, 1'b1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_done(n);
    chk("t4_rb_cycles", 32'(n), 32'd6);
    chk("t4_errs", {30'd0, bus.overflow_err, bus.checksum_err}, 32'd1);
    chk("t4_hold", 32'(bus.cpu_hold), 32'd1);
    corrupt = 1'b0;

    // Reset after 3 of 6 words, with load_start in the same cycle
    do_start();
    send(7'h05, 1'b0);
    send(7'h06, 1'b0);
    send(7'h07, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    bus.load_start = 1'b1;
    step();
    reset = 1'b0;
    bus.load_start = 1'b0;
    chk("t5_rst_ctrl", {27'd0, bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.cpu_hold}, 32'd1);
    chk("t5_rst_addr_cnt", {17'd0, bus.mem_addr, bus.word_count}, 32'd0);
    chk("t5_rst_errs", {30'd0, bus.overflow_err, bus.checksum_err}, 32'd0);
    do_start();
    for (int i = 0; i < 6; i++) send(7'(5 + i), i == 5);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_done(n);
    chk("t5_rb_cycles", 32'(n), 32'd8);
    chk("t5_word_count", 32'(bus.word_count), 32'd6);
    chk("t5_wsum", 32'(dut.wsum), 32'h2D);
    chk("t5_hold_errs", {29'd0, bus.cpu_hold, bus.overflow_err, bus.checksum_err}, 32'd0);

    // Gapped stream, stray in_last without in_valid, load_start during LOAD
    do_start();
    wr_base = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid   = (i % 2 == 0) && (i < 7);
      bus.in_data    = 7'h41 + 7'(i / 2);
      bus.in_last    = (i == 6) || (i == 1);
      bus.load_start = (i == 3);
      step();
      chk($sformatf("t6_we_%0d", i), 32'(bus.mem_we), 32'((i % 2 == 0) && (i < 7)));
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.load_start = 1'b0;
    wait_done(n);
    chk("t6_rb_cycles", 32'(n), 32'd5);
    chk("t6_word_count", 32'(bus.word_count), 32'd4);
    chk("t6_writes", 32'(wr_cnt - wr_base), 32'd4);
    chk("t6_mem", {4'd0, mem[0], mem[1], mem[2], mem[3]}, {4'd0, 7'h41, 7'h42, 7'h43, 7'h44});
    chk("t6_hold_errs", {29'd0, bus.cpu_hold, bus.overflow_err, bus.checksum_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
